wb_ppfifo_2_mem_nbank: RTL and testbench

WB_PPFIFO_2_MEM_NBANK -- requirements
Module: wb_ppfifo_2_mem_nbank

---
 rtl/wb_ppfifo_2_mem_nbank_pkg.sv | 25 ++
 rtl/rr_bank_sel.sv | 31 +++
 rtl/wb_ppfifo_2_mem_nbank.sv | 243 ++++++++++++++++++++++++
 tb/tb_wb_ppfifo_2_mem_nbank.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ppfifo_2_mem_nbank_pkg.sv
// Shared types and constants for the ping-pong FIFO to N-bank Wishbone writer.
package wb_ppfifo_2_mem_nbank_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned FIFO_SIZE_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_WRITE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_BANK_DONE = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

  localparam logic [3:0]        WB_SEL_ALL    = 4'b1111;
  localparam logic [ADDR_W-1:0] DEF_BANK_SPAN = 32'h0000_1000;

  // Default base address of bank k when banks are laid out back to back.
  function automatic logic [ADDR_W-1:0] def_bank_base(input int unsigned k);
    return ADDR_W'(k) * DEF_BANK_SPAN;
  endfunction

endpackage

// File: rtl/rr_bank_sel.sv
// Round-robin pick of the first requesting bank after the last granted one.
module rr_bank_sel
  import wb_ppfifo_2_mem_nbank_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [NUM_BANKS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic [IDX_W-1:0]     grant_c,
  output logic                 valid_c
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned off);
    return IDX_W'((32'(base) + off) % NUM_BANKS);
  endfunction

  // Scan starts one past the last grant so the last grant is checked last.
  always_comb begin
    grant_c = last_i;
    valid_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_BANKS; i++) begin
      if (!valid_c && req_i[wrap_idx(last_i, i)]) begin
        grant_c = wrap_idx(last_i, i);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ppfifo_2_mem_nbank.sv
// Drains ping-pong FIFO blocks into N memory banks over a Wishbone master port.
module wb_ppfifo_2_mem_nbank
  import wb_ppfifo_2_mem_nbank_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned ADDR_STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_enable,
  input  logic [32*NUM_BANKS-1:0]   i_bank_base,
  input  logic [32*NUM_BANKS-1:0]   i_bank_size,
  input  logic [NUM_BANKS-1:0]      i_bank_new_data,
  output logic [32*NUM_BANKS-1:0]   o_bank_count,
  output logic [NUM_BANKS-1:0]      o_bank_empty,
  output logic [NUM_BANKS-1:0]      o_bank_done,
  output logic                      o_error,
  input  logic                      i_clear_error,
  output logic                      o_mem_we,
  output logic                      o_mem_stb,
  output logic                      o_mem_cyc,
  output logic [3:0]                o_mem_sel,
  output logic [ADDR_W-1:0]         o_mem_adr,
  output logic [DATA_W-1:0]         o_mem_dat,
  input  logic                      i_mem_ack,
  input  logic                      i_ppfifo_rdy,
  output logic                      o_ppfifo_act,
  output logic                      o_ppfifo_stb,
  input  logic [FIFO_SIZE_W-1:0]    i_ppfifo_size,
  input  logic [DATA_W-1:0]         i_ppfifo_data
);

  localparam int unsigned IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q [NUM_BANKS];
  logic [ADDR_W-1:0]      ptr_d [NUM_BANKS];
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   act_q, act_d;
  logic [FIFO_SIZE_W-1:0] fcnt_q, fcnt_d;
  logic                   fstb_q, fstb_d;
  logic                   cyc_q, cyc_d;
  logic                   stb_q, stb_d;
  logic                   we_q, we_d;
  logic [3:0]             sel_q;
  logic [DATA_W-1:0]      dat_q, dat_d;
  logic [ADDR_W-1:0]      adr_q, adr_d;
  logic [NUM_BANKS-1:0]   done_q, done_d;
  logic                   err_q, err_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic [ADDR_W-1:0]      base_w [NUM_BANKS];
  logic [ADDR_W-1:0]      size_w [NUM_BANKS];
  logic [NUM_BANKS-1:0]   req_w;
  logic [IDX_W-1:0]       rr_grant;
  logic                   rr_valid;

  // Per-bank views of the flattened buses; a bank requests while words remain.
  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    assign base_w[k]                = i_bank_base[32*k +: 32];
    assign size_w[k]                = i_bank_size[32*k +: 32];
    assign o_bank_count[32*k +: 32] = size_w[k] - ptr_q[k];
    assign o_bank_empty[k]          = (size_w[k] == ptr_q[k]);
    assign req_w[k]                 = (ptr_q[k] < size_w[k]);
  end

  rr_bank_sel #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (IDX_W)
  ) u_rr_bank_sel (
    .req_i   (req_w),
    .last_i  (last_q),
    .grant_c (rr_grant),
    .valid_c (rr_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    last_d  = last_q;
    act_d   = act_q;
    fcnt_d  = fcnt_q;
    fstb_d  = 1'b0;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    dat_d   = dat_q;
    adr_d   = adr_q;
    done_d  = '0;
    err_d   = err_q;
    tmo_d   = tmo_q;

    // Grab a ready FIFO block whenever we are not already holding one.
    if (state_q != ST_ERROR && i_enable && i_ppfifo_rdy && !act_q) begin
      act_d  = 1'b1;
      fcnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        we_d  = 1'b1;
        if (i_enable) state_d = ST_SELECT;
      end

      ST_SELECT: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (rr_valid) begin
          cur_d   = rr_grant;
          last_d  = rr_grant;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (!i_enable) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          act_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (i_bank_new_data[cur_q]) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = ST_SELECT;
        end else if (act_q && (fcnt_q < i_ppfifo_size)) begin
          dat_d   = i_ppfifo_data;
          adr_d   = base_w[cur_q] + ptr_q[cur_q] * ADDR_W'(ADDR_STRIDE);
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_WAIT_ACK;
        end else if (act_q) begin
          // Block exhausted: hand it back so the FIFO can swap halves.
          act_d = 1'b0;
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
      end

      ST_WAIT_ACK: begin
        if (i_mem_ack && stb_q) begin
          stb_d              = 1'b0;
          fstb_d             = 1'b1;
          fcnt_d             = fcnt_q + FIFO_SIZE_W'(1);
          ptr_d[cur_q]       = ptr_q[cur_q] + ADDR_W'(1);
          if (i_bank_new_data[cur_q]) begin
            cyc_d   = 1'b0;
            state_d = ST_SELECT;
          end else if ((ptr_q[cur_q] + ADDR_W'(1)) >= size_w[cur_q]) begin
            done_d[cur_q] = 1'b1;
            state_d       = ST_BANK_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end else if ((32'(tmo_q) + 32'd1) >= ACK_TIMEOUT) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_BANK_DONE: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = ST_SELECT;
      end

      ST_ERROR: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (i_clear_error) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A host rewind beats any increment from a same-cycle ack.
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (i_bank_new_data[k]) ptr_d[k] = '0;
    end

    if (i_clear_error) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < NUM_BANKS; k++) ptr_q[k] <= '0;
      cur_q   <= '0;
      last_q  <= IDX_W'(NUM_BANKS - 1);
      act_q   <= 1'b0;
      fcnt_q  <= '0;
      fstb_q  <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= WB_SEL_ALL;
      dat_q   <= '0;
      adr_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      act_q   <= act_d;
      fcnt_q  <= fcnt_d;
      fstb_q  <= fstb_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= WB_SEL_ALL;
      dat_q   <= dat_d;
      adr_q   <= adr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_mem_cyc    = cyc_q;
  assign o_mem_stb    = stb_q;
  assign o_mem_we     = we_q;
  assign o_mem_sel    = sel_q;
  assign o_mem_adr    = adr_q;
  assign o_mem_dat    = dat_q;
  assign o_ppfifo_act = act_q;
  assign o_ppfifo_stb = fstb_q;
  assign o_bank_done  = done_q;
  assign o_error      = err_q;

endmodule

// File: tb/tb_wb_ppfifo_2_mem_nbank.sv
// Scoreboard bench: expected bus writes and done pulses are queued by the stimulus, popped by a monitor.
module tb_wb_ppfifo_2_mem_nbank;
  import wb_ppfifo_2_mem_nbank_pkg::*;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_enable;
  logic [32*NB-1:0] i_bank_base, i_bank_size;
  logic [NB-1:0]   i_bank_new_data;
  logic [32*NB-1:0] o_bank_count;
  logic [NB-1:0]   o_bank_empty, o_bank_done;
  logic            o_error, i_clear_error;
  logic            o_mem_we, o_mem_stb, o_mem_cyc;
  logic [3:0]      o_mem_sel;
  logic [31:0]     o_mem_adr, o_mem_dat;
  logic            i_mem_ack;
  logic            i_ppfifo_rdy, o_ppfifo_act, o_ppfifo_stb;
  logic [23:0]     i_ppfifo_size;
  logic [31:0]     i_ppfifo_data;

  logic            ack_en;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  checks = 0;
  int  failures = 0;
  int  act_rises = 0;

  logic [31:0] fifo_words [64];
  int          fifo_total = 0;
  int          fifo_blk = 1;
  int          rd_idx = 0;
  logic        blk_active = 1'b0;

  always #5 clk = ~clk;

  assign i_mem_ack = o_mem_stb & ack_en;

  wb_ppfifo_2_mem_nbank #(
    .NUM_BANKS   (NB),
    .ACK_TIMEOUT (16),
    .ADDR_STRIDE (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_enable        (i_enable),
    .i_bank_base     (i_bank_base),
    .i_bank_size     (i_bank_size),
    .i_bank_new_data (i_bank_new_data),
    .o_bank_count    (o_bank_count),
    .o_bank_empty    (o_bank_empty),
    .o_bank_done     (o_bank_done),
    .o_error         (o_error),
    .i_clear_error   (i_clear_error),
    .o_mem_we        (o_mem_we),
    .o_mem_stb       (o_mem_stb),
    .o_mem_cyc       (o_mem_cyc),
    .o_mem_sel       (o_mem_sel),
    .o_mem_adr       (o_mem_adr),
    .o_mem_dat       (o_mem_dat),
    .i_mem_ack       (i_mem_ack),
    .i_ppfifo_rdy    (i_ppfifo_rdy),
    .o_ppfifo_act    (o_ppfifo_act),
    .o_ppfifo_stb    (o_ppfifo_stb),
    .i_ppfifo_size   (i_ppfifo_size),
    .i_ppfifo_data   (i_ppfifo_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ping-pong FIFO model: one block of up to fifo_blk words is offered at a time.
  initial begin
    i_ppfifo_rdy  = 1'b0;
    i_ppfifo_size = '0;
    i_ppfifo_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        blk_active = 1'b0;
      end else begin
        if (o_ppfifo_stb) rd_idx++;
        if (o_ppfifo_act && !blk_active) blk_active = 1'b1;
        else if (!o_ppfifo_act && blk_active) blk_active = 1'b0;
      end
      if (!blk_active)
        i_ppfifo_size = 24'(((fifo_total - rd_idx) < fifo_blk) ? (fifo_total - rd_idx) : fifo_blk);
      i_ppfifo_rdy  = !blk_active && (rd_idx < fifo_total);
      i_ppfifo_data = (rd_idx < 64) ? fifo_words[rd_idx] : 32'hDEAD_BEEF;
    end
  end

  // Monitor: every completed beat and every done pulse must match the queue head.
  initial begin
    wr_t  e;
    int   b;
    logic act_prev;
    act_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act_prev = 1'b0;
      end else begin
        if (o_mem_cyc && o_mem_stb && i_mem_ack) begin
          if (exp_wr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_write: got write adr=0x%0h dat=0x%0h expected none", o_mem_adr, o_mem_dat);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_adr", o_mem_adr, e.adr);
            chk("wr_dat", o_mem_dat, e.dat);
          end
        end
        if (o_bank_done != '0) begin
          if (exp_done.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bank_done: got 0x%0h expected no pulse", o_bank_done);
          end else begin
            b = exp_done.pop_front();
            chk("bank_done", 32'(o_bank_done), 32'(1) << b);
          end
        end
        if (o_ppfifo_act && !act_prev) act_rises++;
        act_prev = o_ppfifo_act;
      end
    end
  end

  task automatic start_reset();
    @(negedge clk);
    rst             = 1'b1;
    i_enable        = 1'b0;
    i_clear_error   = 1'b0;
    i_bank_new_data = '0;
    ack_en          = 1'b1;
    exp_wr.delete();
    exp_done.delete();
    act_rises       = 0;
  endtask

  task automatic load_fifo(input int n, input logic [31:0] first, input int blk);
    for (int i = 0; i < n; i++) fifo_words[i] = first + 32'(i);
    fifo_total = n;
    fifo_blk   = blk;
    rd_idx     = 0;
  endtask

  task automatic push_wr(input logic [31:0] adr, input logic [31:0] dat);
    wr_t w;
    w.adr = adr;
    w.dat = dat;
    exp_wr.push_back(w);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_pending"}, 32'(exp_wr.size() + exp_done.size()), 32'd0);
  endtask

  initial begin
    int t, t_stb, t_err, beats;
    rst = 1'b1;
    i_enable = 1'b0;
    i_clear_error = 1'b0;
    i_bank_new_data = '0;
    ack_en = 1'b1;
    i_bank_base = '0;
    i_bank_size = '0;

    // Two live banks (upper two sized 0), bank 1 empty: only bank 0 is written.
    start_reset();
    i_bank_base = {def_bank_base(4), def_bank_base(3), 32'h0000_2000, 32'h0000_1000};
    i_bank_size = {32'd0, 32'd0, 32'd0, 32'd4};
    load_fifo(4, 32'd1, 4);
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(o_mem_cyc), 32'd0);
    chk("rst_stb", 32'(o_mem_stb), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_sel", 32'(o_mem_sel), 32'hF);
    chk("rst_dat", o_mem_dat, 32'd0);
    chk("rst_act", 32'(o_ppfifo_act), 32'd0);
    chk("rst_fstb", 32'(o_ppfifo_stb), 32'd0);
    chk("rst_err", 32'(o_error), 32'd0);
    chk("rst_done", 32'(o_bank_done), 32'd0);
    chk("rst_count0", o_bank_count[31:0], 32'd4);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push_wr(32'h0000_1000 + 32'(i), 32'(i + 1));
    exp_done.push_back(0);
    i_enable = 1'b1;
    wait_drain("t1", 200);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t1_count0", o_bank_count[31:0], 32'd0);
    chk("t1_empty", 32'(o_bank_empty), 32'hF);
    chk("t1_we", 32'(o_mem_we), 32'd1);

    // Four banks of two words each, served in order 0..3 from one 8-word block.
    start_reset();
    i_bank_base = {32'h400, 32'h300, 32'h200, 32'h100};
    i_bank_size = {32'd2, 32'd2, 32'd2, 32'd2};
    load_fifo(8, 32'h11, 8);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("t2_count2", o_bank_count[95:64], 32'd2);
    for (int k = 0; k < 4; k++) begin
      push_wr(32'h100 * 32'(k + 1),        32'h11 + 32'(2 * k));
      push_wr(32'h100 * 32'(k + 1) + 32'd1, 32'h12 + 32'(2 * k));
      exp_done.push_back(k);
    end
    i_enable = 1'b1;
    wait_drain("t2", 300);
    @(negedge clk);
    chk("t2_empty", 32'(o_bank_empty), 32'hF);
    chk("t2_act_rises", 32'(act_rises), 32'd1);

    // Two-word FIFO blocks into a five-word bank: act is dropped and reacquired.
    start_reset();
    i_bank_base = {32'h0, 32'h0, 32'h0, 32'h40};
    i_bank_size = {32'd0, 32'd0, 32'd0, 32'd5};
    load_fifo(6, 32'hA1, 2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push_wr(32'h40 + 32'(i), 32'hA1 + 32'(i));
    exp_done.push_back(0);
    i_enable = 1'b1;
    wait_drain("t3", 300);
    repeat (5) @(negedge clk);
    chk("t3_act_rises", 32'(act_rises), 32'd3);
    chk("t3_count0", o_bank_count[31:0], 32'd0);

    // Ack withheld: error 16 cycles after strobe, bus released, IDLE after clear.
    start_reset();
    i_bank_base = {32'h0, 32'h0, 32'h0, 32'h80};
    i_bank_size = {32'd0, 32'd0, 32'd0, 32'd4};
    load_fifo(4, 32'h51, 4);
    ack_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    i_enable = 1'b1;
    t = 0; t_stb = -1; t_err = -1;
    while (t < 100 && t_err < 0) begin
      @(negedge clk);
      if (o_mem_stb && t_stb < 0) t_stb = t;
      if (o_error && t_err < 0) t_err = t;
      t++;
    end
    chk("t4_err_delay", 32'(t_err - t_stb), 32'd16);
    chk("t4_err_cyc", 32'(o_mem_cyc), 32'd0);
    chk("t4_err_stb", 32'(o_mem_stb), 32'd0);
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", 32'(o_error), 32'd1);
    chk("t4_state_err", 32'(dut.state_q), 32'(ST_ERROR));
    i_clear_error = 1'b1;
    @(negedge clk);
    i_clear_error = 1'b0;
    chk("t4_err_clr", 32'(o_error), 32'd0);
    chk("t4_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Rewind bank 0 in the same cycle as its third ack.
    start_reset();
    i_bank_base = {32'h0, 32'h0, 32'h0, 32'h800};
    i_bank_size = {32'd0, 32'd0, 32'd0, 32'd4};
    load_fifo(8, 32'h31, 8);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) push_wr(32'h800 + 32'(i), 32'h31 + 32'(i));
    for (int i = 0; i < 4; i++) push_wr(32'h800 + 32'(i), 32'h34 + 32'(i));
    exp_done.push_back(0);
    i_enable = 1'b1;
    t = 0; beats = 0;
    while (beats < 3 && t < 200) begin
      @(negedge clk);
      if (o_mem_stb && i_mem_ack) begin
        beats++;
        if (beats == 3) i_bank_new_data = 4'b0001;
      end
      t++;
    end
    chk("t5_beats", 32'(beats), 32'd3);
    @(negedge clk);
    i_bank_new_data = '0;
    chk("t5_count0_rewound", o_bank_count[31:0], 32'd4);
    wait_drain("t5", 300);
    @(negedge clk);
    chk("t5_count0_final", o_bank_count[31:0], 32'd0);

    i_enable = 1'b0;
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
